// File: rtl/fan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fan_pkg : shared widths, level-width helper and timer preset table       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fan_pkg;

  localparam int TIMER_SEL_W = 2;
  localparam int TIMER_REM_W = 4;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int lvl_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [TIMER_REM_W-1:0] timer_units(input logic [TIMER_SEL_W-1:0] sel);
    case (sel)
      2'd0:    return 4'd0;
      2'd1:    return 4'd4;
      2'd2:    return 4'd8;
      default: return 4'd12;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fan_pwm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fan_pwm_gen : free-running PWM with duty latched at the period boundary  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fan_pwm_gen
  import fan_pkg::*;
#(
  parameter int PWM_PERIOD = 100,
  parameter int NUM_LEVELS = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [lvl_width(NUM_LEVELS)-1:0] i_level,
  output logic                             o_pwm
);

  localparam int LVL_W = lvl_width(NUM_LEVELS);
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam int STEP  = PWM_PERIOD / (NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(NUM_LEVELS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] duty_target;
  logic             pwm_q, pwm_d;

  // Top level uses the full period as duty so rounding never leaves a low gap.
  assign duty_target = (i_level == LVL_MAX) ? CNT_W'(PWM_PERIOD)
                                            : CNT_W'(int'(i_level) * STEP);

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    duty_d = (cnt_q == CNT_LAST) ? duty_target : duty_q;
    pwm_d  = (cnt_d < duty_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/fan_speed_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fan_speed_ctrl : button-driven fan level FSM with PWM output; optional   |
// | auto-off timer enabled by defining FAN_TIMER_EN.  Rev 1.0                |
// +--------------------------------------------------------------------------+
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int PWM_PERIOD = 100
`ifdef FAN_TIMER_EN
  ,
  parameter int TIMER_UNIT_CYCLES = 1000000
`endif
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_button_up,
  input  logic                             i_button_down,
  input  logic                             i_button_off,
`ifdef FAN_TIMER_EN
  input  logic                             i_button_timer,
  output logic [TIMER_SEL_W-1:0]           o_timerSel,
`endif
  output logic [lvl_width(NUM_LEVELS)-1:0] o_fanLevel,
  output logic                             o_pwm
);

  localparam int LVL_W = lvl_width(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LVL_0   = '0;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);

  logic             up_q, down_q, off_q;
  logic             up_press, down_press, off_press;
  logic             expire;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  assign up_press   = i_button_up   & ~up_q;
  assign down_press = i_button_down & ~down_q;
  assign off_press  = i_button_off  & ~off_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      off_q  <= 1'b0;
    end else begin
      up_q   <= i_button_up;
      down_q <= i_button_down;
      off_q  <= i_button_off;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) lvl_q <= LVL_0;
    else         lvl_q <= lvl_d;
  end

  // Timer expiry outranks every button; then off > up > down.
  always_comb begin
    lvl_d = lvl_q;
    if (expire || off_press)
      lvl_d = LVL_0;
    else if (up_press)
      lvl_d = (lvl_q == LVL_MAX) ? lvl_q : lvl_q + 1'b1;
    else if (down_press)
      lvl_d = (lvl_q == LVL_0) ? lvl_q : lvl_q - 1'b1;
  end

  always_comb begin
    o_fanLevel = lvl_q;
  end

`ifdef FAN_TIMER_EN
  localparam int PRESC_W = lvl_width(TIMER_UNIT_CYCLES);

  logic                   timer_q;
  logic                   timer_press, armed, unit_tick;
  logic [TIMER_SEL_W-1:0] sel_q, sel_d;
  logic [TIMER_REM_W-1:0] rem_q, rem_d;
  logic [PRESC_W-1:0]     presc_q, presc_d;

  assign timer_press = i_button_timer & ~timer_q;
  assign armed       = (sel_q != '0);
  assign unit_tick   = (presc_q == PRESC_W'(TIMER_UNIT_CYCLES - 1));
  assign expire      = armed && unit_tick && (rem_q == TIMER_REM_W'(1));

  // Any path to level 0 (expiry, off, down) disarms the timer.
  always_comb begin
    sel_d   = sel_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    if (lvl_d == LVL_0) begin
      sel_d   = '0;
      rem_d   = '0;
      presc_d = '0;
    end else if (timer_press && (lvl_q != LVL_0)) begin
      sel_d   = sel_q + 1'b1;
      rem_d   = timer_units(sel_q + 1'b1);
      presc_d = '0;
    end else if (armed) begin
      if (unit_tick) begin
        presc_d = '0;
        rem_d   = rem_q - 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timer_q <= 1'b0;
      sel_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
    end else begin
      timer_q <= i_button_timer;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
    end
  end

  assign o_timerSel = sel_q;
`else
  assign expire = 1'b0;
`endif

  fan_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD),
    .NUM_LEVELS (NUM_LEVELS)
  ) u_pwm (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level (lvl_q),
    .o_pwm   (o_pwm)
  );

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fan_speed_ctrl : scoreboard bench for the fan level / PWM controller  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fan_speed_ctrl;

  localparam int NL = 4;
  localparam int PP = 100;

  logic       clk = 1'b0;
  logic       rst, up, down, off;
  logic [1:0] lvl;
  logic       pwm;
`ifdef FAN_TIMER_EN
  logic       tmr;
  logic [1:0] tsel;
`endif

  int n_vec = 0;
  int n_err = 0;
  int model_lvl = 0;
  int lvl_exp[$];
  bit pwm_exp[$];

  always #5 clk = ~clk;

  fan_speed_ctrl #(
    .NUM_LEVELS (NL),
    .PWM_PERIOD (PP)
`ifdef FAN_TIMER_EN
    ,
    .TIMER_UNIT_CYCLES (10)
`endif
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_button_up    (up),
    .i_button_down  (down),
    .i_button_off   (off),
`ifdef FAN_TIMER_EN
    .i_button_timer (tmr),
    .o_timerSel     (tsel),
`endif
    .o_fanLevel     (lvl),
    .o_pwm          (pwm)
  );

  function automatic int model_next(input int cur, input logic u, input logic d, input logic o);
    if (o) return 0;
    if (u) return (cur == NL - 1) ? cur : cur + 1;
    if (d) return (cur == 0) ? 0 : cur - 1;
    return cur;
  endfunction

  task automatic press(input logic u, input logic d, input logic o, input string name);
    int e;
    @(negedge clk);
    up = u; down = d; off = o;
    model_lvl = model_next(model_lvl, u, d, o);
    lvl_exp.push_back(model_lvl);
    @(negedge clk);
    up = 1'b0; down = 1'b0; off = 1'b0;
    e = lvl_exp.pop_front();
    n_vec++;
    if (int'(lvl) !== e) begin
      n_err++;
      $display("FAIL %s: level got %0d expected %0d", name, lvl, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b0; down = 1'b0; off = 1'b0;
`ifdef FAN_TIMER_EN
    tmr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_vec++;
    if (lvl !== 2'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", lvl); end
    n_vec++;
    if (pwm !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %0b expected 0", pwm); end
`ifdef FAN_TIMER_EN
    n_vec++;
    if (tsel !== 2'd0) begin n_err++; $display("FAIL reset_timersel: got %0d expected 0", tsel); end
`endif
    rst = 1'b0;
    model_lvl = 0;
    @(negedge clk);
  endtask

  task automatic test_up_down();
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, "up_step");
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0, "down_step");
  endtask

  task automatic test_held();
    int e;
    @(negedge clk);
    up = 1'b1;
    model_lvl = model_next(model_lvl, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) lvl_exp.push_back(model_lvl);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      e = lvl_exp.pop_front();
      n_vec++;
      if (int'(lvl) !== e) begin
        n_err++;
        $display("FAIL held_up cycle %0d: level got %0d expected %0d", i, lvl, e);
      end
    end
    up = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    press(1'b0, 1'b1, 1'b0, "prio_down_to_0");
    press(1'b1, 1'b0, 1'b0, "prio_up1");
    press(1'b1, 1'b0, 1'b0, "prio_up2");
    press(1'b1, 1'b0, 1'b1, "prio_up_off");
    press(1'b1, 1'b0, 1'b0, "prio_up3");
    press(1'b1, 1'b1, 1'b0, "prio_up_down");
  endtask

  task automatic test_pwm();
    logic prev;
    bit   found, e;
    int   bad, el, lows;
    press(1'b0, 1'b1, 1'b0, "pwm_to_level1");
    @(negedge clk);
    prev  = pwm;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (!prev && pwm) found = 1'b1;
      prev = pwm;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL pwm_sync: no rising edge within 300 cycles, got 0 expected 1");
      return;
    end
    for (int i = 0; i < 300; i++) begin
      if (i < 200) pwm_exp.push_back((i % 100) < 33);
      else         pwm_exp.push_back((i - 200) < 66);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      e = pwm_exp.pop_front();
      if (pwm !== e) bad++;
      if (i == 110) begin
        up = 1'b1;
        model_lvl = model_next(model_lvl, 1'b1, 1'b0, 1'b0);
        lvl_exp.push_back(model_lvl);
      end
      if (i == 111) up = 1'b0;
      if (i == 99 || i == 199 || i == 299) begin
        n_vec++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL pwm_period_%0d: %0d sample mismatches, expected 0", i / 100, bad);
        end
        bad = 0;
      end
    end
    el = lvl_exp.pop_front();
    n_vec++;
    if (int'(lvl) !== el) begin n_err++; $display("FAIL pwm_mid_level: got %0d expected %0d", lvl, el); end

    press(1'b1, 1'b0, 1'b0, "pwm_to_level3");
    repeat (200) @(negedge clk);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm !== 1'b1) lows++;
    end
    n_vec++;
    if (lows != 0) begin n_err++; $display("FAIL pwm_level3_const: %0d low samples, expected 0", lows); end
  endtask

  task automatic test_reset_mid();
    int highs;
    n_vec++;
    if (pwm !== 1'b1) begin n_err++; $display("FAIL pre_reset_pwm: got %0b expected 1", pwm); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (lvl !== 2'd0) begin n_err++; $display("FAIL midreset_level: got %0d expected 0", lvl); end
    n_vec++;
    if (pwm !== 1'b0) begin n_err++; $display("FAIL midreset_pwm: got %0b expected 0", pwm); end
    n_vec++;
    if (dut.u_pwm.cnt_q !== '0) begin
      n_err++;
      $display("FAIL midreset_counter: got %0d expected 0", dut.u_pwm.cnt_q);
    end
    rst = 1'b0;
    model_lvl = 0;
    highs = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (pwm !== 1'b0) highs++;
    end
    n_vec++;
    if (highs != 0) begin n_err++; $display("FAIL post_reset_pwm: %0d high samples, expected 0", highs); end
  endtask

`ifdef FAN_TIMER_EN
  task automatic timer_press(input int exp_sel, input string name);
    @(negedge clk);
    tmr = 1'b1;
    @(negedge clk);
    tmr = 1'b0;
    n_vec++;
    if (int'(tsel) !== exp_sel) begin
      n_err++;
      $display("FAIL %s: timersel got %0d expected %0d", name, tsel, exp_sel);
    end
  endtask

  task automatic test_timer();
    int  k;
    bit  hit;
    timer_press(0, "timer_at_level0");
    press(1'b1, 1'b0, 1'b0, "timer_up1");
    press(1'b1, 1'b0, 1'b0, "timer_up2");
    timer_press(1, "timer_sel1");
    k = 0; hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      k++;
      if (lvl == 2'd0) hit = 1'b1;
    end
    n_vec++;
    if (!hit || k < 30 || k > 50) begin
      n_err++;
      $display("FAIL timer_expiry: level reached 0 after %0d cycles (hit=%0b), expected 30..50", k, hit);
    end
    n_vec++;
    if (tsel !== 2'd0) begin n_err++; $display("FAIL timer_expiry_sel: got %0d expected 0", tsel); end
    model_lvl = 0;
    press(1'b1, 1'b0, 1'b0, "timer2_up1");
    press(1'b1, 1'b0, 1'b0, "timer2_up2");
    timer_press(1, "timer2_sel1");
    repeat (15) @(negedge clk);
    press(1'b0, 1'b0, 1'b1, "timer2_off");
    n_vec++;
    if (tsel !== 2'd0) begin n_err++; $display("FAIL timer_off_sel: got %0d expected 0", tsel); end
    repeat (60) @(negedge clk);
    n_vec++;
    if (lvl !== 2'd0 || tsel !== 2'd0) begin
      n_err++;
      $display("FAIL timer_after_off: level %0d sel %0d, expected 0 and 0", lvl, tsel);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_down();
    test_held();
    test_priority();
    test_pwm();
    test_reset_mid();
`ifdef FAN_TIMER_EN
    test_timer();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
